// File: rtl/serial_demux_1to8.sv
// Serial-to-parallel demultiplexer with slot counter, frame sync and a
// double-buffered valid/ready word output.
module serial_demux_1to8 #(
    parameter int WIDTH = 8,
    parameter int SEL_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    input  logic             sync,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [SEL_W-1:0] fill,
    output logic             sync_err
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(WIDTH - 1);

    logic [WIDTH-1:0] asm_q;
    logic [SEL_W-1:0] slot;
    logic             acc;
    logic             complete;
    logic             at_last;

    // Only the completing bit can be stalled; sync always restarts at slot 0.
    assign at_last   = (fill == LAST);
    assign bit_ready = sync | ~(at_last & word_valid & ~word_ready);
    assign acc       = bit_valid & bit_ready;
    assign slot      = sync ? '0 : fill;
    assign complete  = acc & (slot == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill <= '0;
        end else if (acc) begin
            fill <= complete ? '0 : slot + SEL_W'(1);
        end else if (sync) begin
            fill <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q <= '0;
        end else if (acc) begin
            asm_q[slot] <= bit_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_out   <= '0;
            word_valid <= 1'b0;
        end else if (complete) begin
            word_out   <= {bit_in, asm_q[WIDTH-2:0]};
            word_valid <= 1'b1;
        end else if (word_ready) begin
            word_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_err <= 1'b0;
        end else begin
            sync_err <= sync & (fill != '0);
        end
    end

endmodule

// File: tb/tb_serial_demux_1to8.sv
// Directed bench for serial_demux_1to8 with a word scoreboard on the
// output handshake.
module tb_serial_demux_1to8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       bit_in;
    logic       bit_valid;
    logic       bit_ready;
    logic       sync;
    logic [7:0] word_out;
    logic       word_valid;
    logic       word_ready;
    logic [2:0] fill;
    logic       sync_err;

    int errors = 0;
    int checks = 0;
    logic [7:0] q[$];

    serial_demux_1to8 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .sync       (sync),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .fill       (fill),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after each rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        tick();
    endtask

    // Sends the first n bits of w, LSB first; queues w if it completes.
    task automatic send_bits(input logic [7:0] w, input int n,
                             input bit push);
        for (int i = 0; i < n; i++) begin
            if (push && i == 7) q.push_back(w);
            send(w[i]);
        end
        bit_valid = 1'b0;
    endtask

    // Scoreboard: every consumed word must match the next queued word.
    always @(negedge clk) begin
        if (rst_n && word_valid && word_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_underflow observed=%0h expected=none",
                       word_out);
            end else begin
                chk("sb_word", word_out, q.pop_front());
            end
        end
    end

    logic [7:0] stream [4];

    initial begin
        rst_n      = 1'b0;
        bit_in     = 1'b0;
        bit_valid  = 1'b0;
        sync       = 1'b0;
        word_ready = 1'b0;
        stream     = '{8'h12, 8'h34, 8'h56, 8'h78};

        // 1: reset state
        tick();
        tick();
        chk("rst_valid", word_valid, 0);
        chk("rst_word", word_out, 0);
        chk("rst_fill", fill, 0);
        chk("rst_ready", bit_ready, 1);
        chk("rst_syncerr", sync_err, 0);
        rst_n = 1'b1;
        tick();

        // 2: one word, consumer always ready
        word_ready = 1'b1;
        send_bits(8'h9A, 8, 1'b1);
        chk("t2_valid", word_valid, 1);
        chk("t2_word", word_out, 8'h9A);
        chk("t2_fill", fill, 0);
        tick();
        chk("t2_valid_drop", word_valid, 0);

        // 3: backpressure on the completing bit
        word_ready = 1'b0;
        send_bits(8'hFF, 8, 1'b1);
        send_bits(8'h00, 7, 1'b0);
        chk("t3_hold_word", word_out, 8'hFF);
        chk("t3_hold_valid", word_valid, 1);
        chk("t3_fill7", fill, 7);
        bit_valid = 1'b1;
        bit_in    = 1'b0;
        #1;
        chk("t3_stall", bit_ready, 0);
        tick();
        chk("t3_stall_fill", fill, 7);
        chk("t3_stall_word", word_out, 8'hFF);
        word_ready = 1'b1;
        q.push_back(8'h00);
        #1;
        chk("t3_release", bit_ready, 1);
        tick();
        bit_valid = 1'b0;
        chk("t3_new_word", word_out, 8'h00);
        chk("t3_new_valid", word_valid, 1);
        tick();
        chk("t3_drained", word_valid, 0);

        // 4: sync discards a partial word
        send_bits(8'h05, 3, 1'b0);
        chk("t4_fill3", fill, 3);
        sync      = 1'b1;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        tick();
        sync = 1'b0;
        chk("t4_syncerr", sync_err, 1);
        chk("t4_fill1", fill, 1);
        send(1'b1);
        chk("t4_syncerr_off", sync_err, 0);
        send(1'b1);
        send(1'b1);
        send(1'b1);
        send(1'b1);
        send(1'b1);
        q.push_back(8'hFF);
        send(1'b1);
        bit_valid = 1'b0;
        chk("t4_word", word_out, 8'hFF);
        chk("t4_valid", word_valid, 1);
        tick();

        // 5: asynchronous reset with a pending word and a partial word
        word_ready = 1'b0;
        send_bits(8'hA5, 8, 1'b0);
        send_bits(8'h1F, 5, 1'b0);
        chk("t5_pre_valid", word_valid, 1);
        chk("t5_pre_fill", fill, 5);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_valid", word_valid, 0);
        chk("t5_word", word_out, 0);
        chk("t5_fill", fill, 0);
        chk("t5_ready", bit_ready, 1);
        chk("t5_syncerr", sync_err, 0);
        #2 rst_n = 1'b1;
        tick();
        word_ready = 1'b1;
        send_bits(8'h3C, 8, 1'b1);
        chk("t5_word_3c", word_out, 8'h3C);
        tick();

        // 6: continuous stream, no gaps
        for (int w = 0; w < 4; w++) begin
            for (int i = 0; i < 8; i++) begin
                bit_valid = 1'b1;
                bit_in    = stream[w][i];
                if (i == 7) q.push_back(stream[w]);
                #1;
                chk("t6_ready", bit_ready, 1);
                tick();
            end
            chk("t6_word", word_out, stream[w]);
        end
        bit_valid = 1'b0;
        tick();
        tick();
        chk("sb_drain", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
